// File: rtl/mds_mix_seq.sv
// Sequential MDS column mixer over GF(2^8).
// The captured word y0..y3 is multiplied by the constant 4x4 MDS matrix,
// producing one output byte per cycle, so a result takes 4 cycles.
module mds_mix_seq #(
    parameter logic [7:0] GF_POLY = 8'h69
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Z,
    output logic        busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ROWS   = 4;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned WORD_W = BYTE_W * ROWS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   y_q;
    logic [ROW_W-1:0]    row;
    logic                accept;
    logic                write_row;

    logic [BYTE_W-1:0]   y_b  [ROWS];
    logic [BYTE_W-1:0]   p_ef [ROWS];
    logic [BYTE_W-1:0]   p_5b [ROWS];
    logic [BYTE_W-1:0]   row_byte;

    // Multiply by x, reducing with the implicit x^8 term folded into GF_POLY.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
        return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_POLY : BYTE_W'(0));
    endfunction

    // Constant multiply by shift-and-conditional-XOR.
    function automatic logic [BYTE_W-1:0] gf_mul_const(input logic [BYTE_W-1:0] a,
                                                      input logic [BYTE_W-1:0] k);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (k[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Byte split and the two non-trivial constant products for every input byte.
    always_comb begin
        for (int j = 0; j < int'(ROWS); j++) begin
            y_b[j]  = y_q[j*BYTE_W +: BYTE_W];
            p_ef[j] = gf_mul_const(y_b[j], 8'hEF);
            p_5b[j] = gf_mul_const(y_b[j], 8'h5B);
        end
    end

    // Matrix row selected by the row counter.
    always_comb begin
        row_byte = '0;
        case (row)
            2'd0:    row_byte = y_b[0]  ^ p_ef[1] ^ p_5b[2] ^ p_5b[3];
            2'd1:    row_byte = p_5b[0] ^ p_ef[1] ^ p_ef[2] ^ y_b[3];
            2'd2:    row_byte = p_ef[0] ^ p_5b[1] ^ y_b[2]  ^ p_ef[3];
            default: row_byte = p_ef[0] ^ y_b[1]  ^ p_ef[2] ^ p_5b[3];
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and datapath strobes; in_ready gates acceptance so nothing
    // is taken before the first edge after reset.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        write_row  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                write_row = 1'b1;
                if (row == ROW_W'(ROWS - 1)) next_state = DONE;
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            busy      <= (next_state == CALC);
            out_valid <= (next_state == DONE);
        end
    end

    // Input capture, row counter and per-row result write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            row <= '0;
            Z   <= '0;
        end else begin
            if (accept) begin
                y_q <= Y;
                row <= '0;
            end else if (write_row) begin
                Z[row*BYTE_W +: BYTE_W] <= row_byte;
                row                     <= row + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mds_mix_seq.sv
// Self-checking bench for mds_mix_seq against a polynomial-arithmetic MDS model.
module tb_mds_mix_seq;

    localparam logic [7:0] POLY = 8'h69;
    localparam logic [7:0] MAT [4][4] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Z;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_z   = '0;

    mds_mix_seq #(.GF_POLY(POLY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Full carry-less product, then reduce from the top by {1,POLY}.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [15:0] m;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        m = {7'b0, 1'b1, POLY};
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (m << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] mds_ref(input logic [31:0] y);
        logic [31:0] z;
        logic [7:0]  acc;
        z = '0;
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
                acc = acc ^ gmul(MAT[i][j], y[8*j +: 8]);
            z[8*i +: 8] = acc;
        end
        return z;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word through, checking latency, partial writes, hold and handshake.
    task automatic run_word(input string tag, input logic [31:0] y,
                            input logic [31:0] exp, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        Y        = y;
        step();
        in_valid = 1'b0;
        Y        = $urandom;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " early_valid"}, 32'(out_valid), 32'd0);
        step();
        n = 1;
        check({tag, " row0_partial"}, Z, {last_z[31:8], exp[7:0]});
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " Z"}, Z, exp);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            Y        = $urandom;
            step();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_Z"}, Z, exp);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, " back_idle"}, 32'(in_ready), 32'd1);
        step();
        check({tag, " no_spurious"}, 32'(busy), 32'd0);
        last_z = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ry;
        logic [31:0] exp_q [$];
        logic [31:0] exp_z;
        int          got;
        int          cyc;
        int          last_cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Y         = '0;
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst Z", Z, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        check("pre_edge in_ready", 32'(in_ready), 32'd0);
        step();
        check("post_rst in_ready", 32'(in_ready), 32'd1);

        run_word("v_y0", 32'h0000_0001, 32'hEFEF_5B01, 0);
        run_word("v_y3", 32'h0100_0000, 32'h5BEF_015B, 0);
        run_word("v_zero", 32'h0000_0000, 32'h0000_0000, 0);
        run_word("v_ones", 32'h0101_0101, 32'h5A5A_5AEE, 0);
        for (int k = 0; k < 3; k++) begin
            ry = $urandom;
            run_word("rand", ry, mds_ref(ry), 0);
        end
        ry = $urandom;
        run_word("hold", ry, mds_ref(ry), 10);

        // Reset while row 2 is about to be computed.
        in_valid = 1'b1;
        Y        = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst Z", Z, 32'd0);
        step();
        step();
        rst    = 1'b0;
        last_z = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            check("after_rst no_valid", 32'(out_valid), 32'd0);
        end
        run_word("post_rst", 32'h0000_0001, 32'hEFEF_5B01, 0);

        // Back-to-back streaming with both handshakes held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        Y         = $urandom;
        got       = 0;
        cyc       = 0;
        last_cyc  = -1;
        while (got < 1000 && cyc < 7000) begin
            if (in_ready) exp_q.push_back(mds_ref(Y));
            step();
            cyc++;
            Y = $urandom;
            if (out_valid) begin
                exp_z = (exp_q.size() > 0) ? exp_q.pop_front() : ~Z;
                check("b2b Z", Z, exp_z);
                if (last_cyc >= 0) check("b2b interval", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                got++;
            end
        end
        check("b2b count", 32'(got), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mds_mix_seq.md
MDS_MIX_SEQ -- requirements
Module: mds_mix_seq

Interface
REQ-001 SHALL have parameter GF_POLY, default 8'h69, giving the low 8 bits of the GF(2^8) reduction polynomial; bit 8 is implicit, so the default field is x^8+x^6+x^5+x^3+1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: Y holds a valid word.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-006 SHALL have port Y, input, 32 bits: q-permuted bytes y0..y3, with y0 = Y[7:0] and y3 = Y[31:24].
REQ-007 SHALL have port out_valid, output, 1 bit: Z holds a valid result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts Z.
REQ-009 SHALL have port Z, output, 32 bits: MDS product z0..z3, with z0 = Z[7:0].
REQ-010 SHALL have port busy, output, 1 bit: high in the CALC state.

Function
REQ-011 SHALL compute z_i = XOR over j of M[i][j]*y_j in GF(2^8) mod {1,GF_POLY}, using rows M0=(01,EF,5B,5B), M1=(5B,EF,EF,01), M2=(EF,5B,01,EF), M3=(EF,01,EF,5B).
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; when in_valid=1 in IDLE, it SHALL capture Y, clear row counter to 0 and go to CALC.
REQ-014 SHALL compute exactly one output byte per cycle in CALC, byte z_row, written into Z[8*row+:8]; row increments 0->3.
REQ-015 SHALL leave CALC for DONE on the edge that writes row 3; the row counter SHALL wrap to 0.
REQ-016 SHALL hold out_valid=1 in DONE, and Z together with out_valid SHALL stay stable until out_ready=1.
REQ-017 SHALL return from DONE to IDLE on the edge where out_valid=1 and out_ready=1; out_valid SHALL drop the next cycle.
REQ-018 SHALL assert out_valid on the 4th rising edge after the accepting edge, so latency is 4 cycles.
REQ-019 SHALL have a minimum initiation interval of 6 cycles; it SHALL NOT accept a new word in the same cycle a result is consumed.
REQ-020 SHALL ignore in_valid and Y outside IDLE; the captured Y SHALL NOT change during CALC or DONE.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL perform all constant multiplies as shift-and-conditional-XOR with GF_POLY reduction, with no lookup tables.
REQ-023 SHALL leave Z bytes for rows not yet computed at their prior value; Z is only valid when out_valid=1.

Reset
REQ-024 SHALL, while rst=1, immediately force state=IDLE, row=0, Z=0, captured Y=0, out_valid=0, busy=0 and in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first rising edge after rst deasserts.
REQ-026 SHALL, when reset hits mid-CALC or in DONE, discard the in-flight word and produce no out_valid until a new word is accepted.

Verification
REQ-027 SHALL pass: Y=32'h00000001 accepted -> after 4 cycles out_valid=1, Z=32'hEFEF5B01.
REQ-028 SHALL pass: Y=32'h01000000 -> Z=32'h5BEF015B; Y=32'h00000000 -> Z=32'h00000000.
REQ-029 SHALL pass: Y=32'h01010101 -> Z=32'h5A5A5AEE.
REQ-030 SHALL pass: out_ready held 0 for 10 cycles in DONE -> out_valid and Z stay constant, in_ready=0, and in_valid pulses with other Y are ignored.
REQ-031 SHALL pass: rst asserted at row 2 of CALC -> outputs are at reset values at once, and the next accepted Y=32'h00000001 gives Z=32'hEFEF5B01.
REQ-032 SHALL pass: back-to-back words with in_valid and out_ready held high -> one result every 6 cycles, with each Z matching a software MDS model over 1000 random Y.
